// File: rtl/fetch_unit.sv
// Instruction fetch: owns the PC, tracks the single in-flight imem read and keeps a one-entry skid buffer.
// First instruction is valid 1 cycle after reset; a redirect costs 2 cycles; stall parks the presented word in the skid.
module fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000
) (
  input  logic        clk,
  input  logic        rst,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  input  logic        stall,
  input  logic        redirect_valid,
  input  logic [31:0] redirect_pc,
  output logic        inst_valid,
  output logic [31:0] inst,
  output logic [31:0] inst_pc
);

  logic [31:0] f_pc;
  logic [31:0] r_pc;
  logic        v;
  logic        s_v;
  logic [31:0] s_inst;
  logic [31:0] s_pc;
  logic        issue;

  assign imem_addr  = f_pc;
  assign inst_valid = s_v | v;
  assign inst       = s_v ? s_inst : imem_rdata;
  assign inst_pc    = s_v ? s_pc : r_pc;
  // Stall only matters when something is presented; otherwise keep refilling.
  assign issue      = ~(stall & inst_valid);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      f_pc   <= RESET_PC;
      r_pc   <= 32'd0;
      v      <= 1'b0;
      s_v    <= 1'b0;
      s_inst <= 32'd0;
      s_pc   <= 32'd0;
    end else if (redirect_valid) begin
      f_pc <= redirect_pc & ~32'd3;
      v    <= 1'b0;
      s_v  <= 1'b0;
    end else if (issue) begin
      r_pc <= f_pc;
      v    <= 1'b1;
      f_pc <= f_pc + 32'd4;
      s_v  <= 1'b0;
    end else if (v && !s_v) begin
      // Read data lives only this cycle; capture it. The read of f_pc is dropped and reissued on release.
      s_inst <= imem_rdata;
      s_pc   <= r_pc;
      s_v    <= 1'b1;
      v      <= 1'b0;
    end else begin
      v <= 1'b0;
    end
  end

endmodule
